// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared constants and load-state type for the programmable clock divider
package clock_gen_pkg;
   localparam int DIV_MIN = 2;
   localparam logic [7:0] TOGGLE_INC = 8'd3;
   localparam logic [7:0] TOGGLE_DEC = 8'd5;
   localparam logic [7:0] TOGGLE_RST = 8'h01;
   typedef enum logic {LD_IDLE, LD_PEND} ld_state_t;
endpackage

// File: rtl/clock_div_prog_if.sv
// clock_div_prog_if: control and status bundle of the programmable divider
interface clock_div_if #(parameter int DIV_W = 8);
   logic en;
   logic [DIV_W-1:0] div_val;
   logic div_load;
   logic div_busy;
   logic div_ack;
   logic div_err;
   logic clk_out;
   logic strobe;
   logic [7:0] toggle_counter;
   modport master (
      output en, div_val, div_load,
      input div_busy, div_ack, div_err, clk_out, strobe, toggle_counter
   );
   modport slave (
      input en, div_val, div_load,
      output div_busy, div_ack, div_err, clk_out, strobe, toggle_counter
   );
endinterface

// File: rtl/div_period_counter.sv
// div_period_counter: period counter, wrap detect and registered square wave
module div_period_counter #(
   parameter int DIV_W = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [DIV_W-1:0] div_reg,
   output logic             wrap,
   output logic             clk_out
);
   logic [DIV_W-1:0] cnt, cnt_nxt;
   assign wrap = en & (cnt == div_reg - 1'b1);
   assign cnt_nxt = (restart | wrap) ? '0 : en ? cnt + 1'b1 : cnt;
   // a restart always lands on cnt==0, which is in the high half of any divisor >= 2
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         cnt <= '0;
         clk_out <= 1'b1;
      end else begin
         cnt <= cnt_nxt;
         clk_out <= restart | (cnt_nxt < (div_reg >> 1));
      end
endmodule

// File: rtl/clock_div_prog.sv
// clock_div_prog: runtime-programmable clock-enable divider with strobe, square wave
// and strobe-stepped toggle counter; divisor changes apply only on a period boundary
module clock_div_prog
   import clock_gen_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 26
) (
   input logic        clk_in,
   input logic        rst,
   clock_div_if.slave bus
);
   ld_state_t state;
   logic [DIV_W-1:0] div_reg, pend_val;
   logic wrap, accept, reject, apply, step_phase;
   assign accept = bus.div_load & (state == LD_IDLE);
   assign reject = accept & (bus.div_val < DIV_W'(DIV_MIN));
   // a frozen period has no boundary to wait for, so apply immediately
   assign apply = (state == LD_PEND) & (wrap | ~bus.en);
   assign bus.div_busy = state == LD_PEND;
   div_period_counter #(.DIV_W(DIV_W)) u_cnt (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (bus.en),
      .restart (apply),
      .div_reg (div_reg),
      .wrap    (wrap),
      .clk_out (bus.clk_out)
   );
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state <= LD_IDLE;
         div_reg <= DIV_W'(DIV_DEFAULT);
         pend_val <= '0;
         bus.div_ack <= 1'b0;
         bus.div_err <= 1'b0;
         bus.strobe <= 1'b0;
         bus.toggle_counter <= TOGGLE_RST;
         step_phase <= 1'b0;
      end else begin
         bus.div_ack <= apply;
         bus.div_err <= reject;
         bus.strobe <= wrap;
         if (wrap) begin
            bus.toggle_counter <= step_phase ? bus.toggle_counter - TOGGLE_DEC : bus.toggle_counter + TOGGLE_INC;
            step_phase <= ~step_phase;
         end
         if (apply) begin
            div_reg <= pend_val;
            state <= LD_IDLE;
         end else if (accept & ~reject) begin
            pend_val <= bus.div_val;
            state <= LD_PEND;
         end
      end
endmodule
